// File: rtl/node_integrator_pkg.sv
// Types and helpers shared by the node integrator and future node banks.
`ifndef NODE_COMMON_SVH
`include "node_common.sv"
`endif

package node_integrator_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    STABLE = 1'b1
  } node_state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/node_common.sv
// Shared node-level constants: voltage width, supply rails, adder width and
// the saturation bounds used by node stages.
`ifndef NODE_COMMON_SVH
`define NODE_COMMON_SVH

`define W 16
`define HI (16384)
`define LO (-16384)

`define NODE_SUM_W (`W+5)
`define NODE_SAT_MAX `HI
`define NODE_SAT_MIN `LO

`endif

// File: rtl/node_current_sum.sv
// Combinational N-input signed current adder followed by the capacitance
// shift; produces the per-cycle voltage step of one node.
`ifndef NODE_COMMON_SVH
`include "node_common.sv"
`endif

module node_current_sum #(
  parameter int N         = 4,
  parameter int CAP_SHIFT = 2
) (
  input  logic [N*`W-1:0]               i_bus,
  output logic signed [`NODE_SUM_W-1:0] delta
);

  logic signed [`NODE_SUM_W-1:0] sum;

  // Five guard bits keep sixteen full-scale contributions from wrapping.
  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) begin
      sum = sum + {{5{i_bus[k*`W+`W-1]}}, i_bus[k*`W +: `W]};
    end
    delta = sum >>> CAP_SHIFT;
  end

endmodule

// File: rtl/node_integrator.sv
// Node voltage integrator with clamp, logic level, toggle strobe and settle FSM.
// Optional macro NODE_LOGIC_HYST_EN: derive lvl from a Schmitt latch on v.
`ifndef NODE_COMMON_SVH
`include "node_common.sv"
`endif

module node_integrator
  import node_integrator_pkg::*;
#(
  parameter int N             = 4,
  parameter int CAP_SHIFT     = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int STABLE_TOL    = 1,
  parameter int INIT          = 0
) (
  input  logic                  eclk,
  input  logic                  erst,
  input  logic [N*`W-1:0]       i_bus,
  input  logic                  force_en,
  input  logic                  force_val,
  output logic signed [`W-1:0]  v,
  output logic                  lvl,
  output logic                  toggle,
  output logic                  stable
);

  localparam logic signed [`W+5:0] SAT_HI = (`W+6)'(`NODE_SAT_MAX);
  localparam logic signed [`W+5:0] SAT_LO = (`W+6)'(`NODE_SAT_MIN);
  localparam logic signed [`W-1:0] V_HI   = (`W)'(`HI);
  localparam logic signed [`W-1:0] V_LO   = (`W)'(`LO);
  localparam logic signed [`W-1:0] INIT_V = (INIT != 0) ? V_HI : V_LO;
  localparam logic signed [`NODE_SUM_W-1:0] TOL = (`NODE_SUM_W)'(STABLE_TOL);
  localparam logic [8:0] SETTLE_TGT = 9'(SETTLE_CYCLES);

  logic signed [`NODE_SUM_W-1:0] delta;
  logic signed [`W+5:0]          vn;
  logic signed [`W-1:0]          v_next;
  logic                          quiet;
  logic                          lvl_next;
  logic                          stable_next;
  logic [CNT_W-1:0]              cnt, cnt_next;
  node_state_t                   state, state_next;

  node_current_sum #(
    .N         (N),
    .CAP_SHIFT (CAP_SHIFT)
  ) u_sum (
    .i_bus (i_bus),
    .delta (delta)
  );

  // Quietness is judged on the unclamped step, so a pinned rail never settles.
  assign vn    = {{6{v[`W-1]}}, v} + {delta[`NODE_SUM_W-1], delta};
  assign quiet = !force_en && (delta <= TOL) && (delta >= -TOL);

  always_ff @(posedge eclk) begin
    if (!erst) begin
      v      <= INIT_V;
      toggle <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      state  <= SETTLE;
    end else begin
      v      <= v_next;
      toggle <= (lvl_next != lvl);
      stable <= stable_next;
      cnt    <= cnt_next;
      state  <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (force_en || !quiet) begin
      state_next = SETTLE;
      cnt_next   = '0;
    end else if (state == SETTLE) begin
      cnt_next = sat_inc(cnt);
      if (({1'b0, cnt} + 9'd1) == SETTLE_TGT) begin
        state_next = STABLE;
      end
    end
  end

  always_comb begin
    stable_next = (state_next == STABLE);
    if (force_en) begin
      v_next = force_val ? V_HI : V_LO;
    end else if (vn > SAT_HI) begin
      v_next = V_HI;
    end else if (vn < SAT_LO) begin
      v_next = V_LO;
    end else begin
      v_next = vn[`W-1:0];
    end
  end

`ifdef NODE_LOGIC_HYST_EN
  localparam logic signed [`W-1:0] TH_HI = (`W)'(`HI / 2);
  localparam logic signed [`W-1:0] TH_LO = (`W)'(`LO / 2);

  logic hyst;

  // The latch follows v_next so lvl always describes the registered v.
  always_comb begin
    lvl_next = hyst;
    if (force_en) begin
      lvl_next = force_val;
    end else if (v_next >= TH_HI) begin
      lvl_next = 1'b1;
    end else if (v_next <= TH_LO) begin
      lvl_next = 1'b0;
    end
  end

  always_ff @(posedge eclk) begin
    if (!erst) begin
      hyst <= (INIT != 0);
    end else begin
      hyst <= lvl_next;
    end
  end

  assign lvl = hyst;
`else
  assign lvl_next = ~v_next[`W-1];
  assign lvl      = ~v[`W-1];
`endif

endmodule
